// File: rtl/route_sched.sv
// Route scheduler: shares the controller cmd/cmd_rdy port between host commands and a 4-entry route queue.
// Latency: IDLE to cmd_rdy 1 clk, arrival to arrived pulse 1 clk, DWELL lasts exactly DWELL_CYCLES clocks.
// Backpressure: cmd_rdy is held until clr_cmd_rdy; a push into a full queue is dropped; a host command waits out ISSUE.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   host_cmd/host_cmd_rdy   host command ([7:6] opcode 01 go / 00 stop, [5:0] station) and its level valid
//   host_clr_cmd_rdy        one-cycle clear back to the host receiver, coincident with clr_cmd_rdy in HOST
//   route_wr/route_id       push a destination station ID into the queue
//   cmd/cmd_rdy             registered command and valid towards the controller
//   clr_cmd_rdy             controller's one-cycle accept
//   in_transit              controller in-transit flag
//   route_full/route_empty  queue occupancy flags
//   route_busy              scheduler not in IDLE
//   arrived                 one-cycle pulse when a route station is reached
//
// Build option: define ROUTE_LOOP_EN for patrol mode (each issued ID is re-queued at the tail).
module route_sched #(
    parameter logic [25:0] DWELL_CYCLES = 26'd50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] host_cmd,
    input  logic       host_cmd_rdy,
    output logic       host_clr_cmd_rdy,
    input  logic       route_wr,
    input  logic [5:0] route_id,
    output logic [7:0] cmd,
    output logic       cmd_rdy,
    input  logic       clr_cmd_rdy,
    input  logic       in_transit,
    output logic       route_full,
    output logic       route_empty,
    output logic       route_busy,
    output logic       arrived
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_TRAVEL = 3'd2;
    localparam logic [2:0] S_DWELL  = 3'd3;
    localparam logic [2:0] S_HOST   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        arrived_q, arrived_d;
    logic [25:0] dwell_q, dwell_d;

    logic [5:0]  mem_q [4];
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  count_q;

    logic        pop;
    logic        flush;
    logic        enter_host;
    logic        push_ok;
    logic        repush;
    logic [1:0]  push_idx;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        arrived_d  = 1'b0;
        dwell_d    = dwell_q;
        pop        = 1'b0;
        flush      = 1'b0;
        enter_host = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host_cmd_rdy) begin
                    enter_host = 1'b1;
                end else if ((count_q != 3'd0) && !in_transit) begin
                    cmd_d     = {2'b01, mem_q[rd_ptr_q]};
                    cmd_rdy_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            // Host commands are not allowed to interrupt a pending handshake;
            // they are picked up from TRAVEL one clock later.
            S_ISSUE: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    pop       = 1'b1;
                    state_d   = S_TRAVEL;
                end
            end
            S_TRAVEL: begin
                if (host_cmd_rdy) begin
                    enter_host = 1'b1;
                end else if (!in_transit) begin
                    arrived_d = 1'b1;
                    dwell_d   = DWELL_CYCLES - 26'd1;
                    state_d   = S_DWELL;
                end
            end
            S_DWELL: begin
                if (host_cmd_rdy) begin
                    enter_host = 1'b1;
                end else if (dwell_q == 26'd0) begin
                    state_d = S_IDLE;
                end else begin
                    dwell_d = dwell_q - 26'd1;
                end
            end
            S_HOST: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cmd_rdy_d = 1'b0;
            end
        endcase

        // Host takeover: abandon the route entirely and forward the host command.
        if (enter_host) begin
            flush     = 1'b1;
            dwell_d   = 26'd0;
            cmd_d     = host_cmd;
            cmd_rdy_d = 1'b1;
            state_d   = S_HOST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= 8'h00;
            cmd_rdy_q <= 1'b0;
            arrived_q <= 1'b0;
            dwell_q   <= 26'd0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            arrived_q <= arrived_d;
            dwell_q   <= dwell_d;
        end
    end

    // ------------------------------------------------------------------
    // Route queue
    // ------------------------------------------------------------------
    assign push_ok = route_wr && (count_q != 3'd4);

`ifdef ROUTE_LOOP_EN
    // Patrol: the popped head goes straight back to the tail, so the
    // occupancy is unchanged by an issue.
    assign repush = pop;
`else
    assign repush = 1'b0;
`endif

    // An external push lands behind a same-cycle re-push.
    assign push_idx = wr_ptr_q + {1'b0, repush};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            mem_q[0] <= 6'd0;
            mem_q[1] <= 6'd0;
            mem_q[2] <= 6'd0;
            mem_q[3] <= 6'd0;
        end else if (flush) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            if (repush) begin
                mem_q[wr_ptr_q] <= mem_q[rd_ptr_q];
            end
            if (push_ok) begin
                mem_q[push_idx] <= route_id;
            end
            wr_ptr_q <= wr_ptr_q + {1'b0, repush} + {1'b0, push_ok};
            count_q  <= count_q - {2'b00, pop} + {2'b00, repush} + {2'b00, push_ok};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd              = cmd_q;
    assign cmd_rdy          = cmd_rdy_q;
    assign arrived          = arrived_q;
    assign host_clr_cmd_rdy = (state_q == S_HOST) && clr_cmd_rdy;
    assign route_full       = (count_q == 3'd4);
    assign route_empty      = (count_q == 3'd0);
    assign route_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_route_sched.sv
module tb_route_sched;

    localparam logic [25:0] D = 26'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] host_cmd;
    logic       host_cmd_rdy;
    logic       host_clr_cmd_rdy;
    logic       route_wr;
    logic [5:0] route_id;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic       in_transit;
    logic       route_full;
    logic       route_empty;
    logic       route_busy;
    logic       arrived;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] issued [$];
    int         arr_cyc [$];
    int         rise_cyc [$];
    int         hclr_cnt  = 0;
    int         bad_coinc = 0;
    logic       prev_rdy  = 1'b0;

    int   travel_len   = 20;
    logic hold_transit = 1'b0;
    int   acc  = 0;
    int   tcnt = 0;

    route_sched #(.DWELL_CYCLES(D)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host_cmd         (host_cmd),
        .host_cmd_rdy     (host_cmd_rdy),
        .host_clr_cmd_rdy (host_clr_cmd_rdy),
        .route_wr         (route_wr),
        .route_id         (route_id),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .in_transit       (in_transit),
        .route_full       (route_full),
        .route_empty      (route_empty),
        .route_busy       (route_busy),
        .arrived          (arrived)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Controller model: accepts cmd_rdy on its 3rd cycle, a go keeps it in transit for travel_len clocks.
    initial begin
        clr_cmd_rdy = 1'b0;
        in_transit  = 1'b0;
        forever begin
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            if (!rst_n) begin
                acc  = 0;
                tcnt = 0;
            end else if (cmd_rdy) begin
                acc = acc + 1;
                if (acc == 3) begin
                    clr_cmd_rdy = 1'b1;
                    acc = 0;
                    issued.push_back(cmd);
                    tcnt = (cmd[7:6] == 2'b01) ? travel_len : 0;
                end
            end else if (tcnt != 0) begin
                tcnt = tcnt - 1;
            end
            in_transit = hold_transit || (tcnt != 0);
        end
    end

    // Event recorder, sampled after all negedge-time drives have settled.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (arrived) arr_cyc.push_back(cyc);
            if (cmd_rdy && !prev_rdy) rise_cyc.push_back(cyc);
            if (host_clr_cmd_rdy) hclr_cnt = hclr_cnt + 1;
            if (host_clr_cmd_rdy && !clr_cmd_rdy) bad_coinc = bad_coinc + 1;
        end
        prev_rdy = cmd_rdy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] id);
        route_wr = 1'b1;
        route_id = id;
        tick();
        route_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        host_cmd = 8'h00; host_cmd_rdy = 1'b0; route_wr = 1'b0; route_id = 6'd0;
        repeat (3) tick();
        n_checks++; if (cmd !== 8'h00)          begin n_fail++; $display("FAIL rst_cmd: got %h want 00", cmd); end
        n_checks++; if (cmd_rdy !== 1'b0)       begin n_fail++; $display("FAIL rst_cmd_rdy: got %b want 0", cmd_rdy); end
        n_checks++; if (host_clr_cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_host_clr: got %b want 0", host_clr_cmd_rdy); end
        n_checks++; if (arrived !== 1'b0)       begin n_fail++; $display("FAIL rst_arrived: got %b want 0", arrived); end
        n_checks++; if (route_empty !== 1'b1)   begin n_fail++; $display("FAIL rst_empty: got %b want 1", route_empty); end
        n_checks++; if (route_full !== 1'b0)    begin n_fail++; $display("FAIL rst_full: got %b want 0", route_full); end
        n_checks++; if (route_busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b want 0", route_busy); end
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++; if (route_busy !== 1'b0)    begin n_fail++; $display("FAIL post_rst_busy: got %b want 0", route_busy); end
    endtask

    task automatic test_route_basic();
        int n;
        issued.delete(); arr_cyc.delete(); rise_cyc.delete();
        push(6'd5);
        push(6'd9);
        n_checks++; if (route_empty !== 1'b0) begin n_fail++; $display("FAIL basic_not_empty: got %b want 0", route_empty); end
        for (n = 0; n < 400 && !(issued.size() == 2 && arr_cyc.size() == 2 && !route_busy); n++) tick();
        n_checks++; if (!(issued.size() == 2 && arr_cyc.size() == 2 && !route_busy)) begin
            n_fail++; $display("FAIL basic_timeout: issued %0d arrived %0d busy %b", issued.size(), arr_cyc.size(), route_busy);
        end
        n_checks++; if (issued[0] !== 8'h45) begin n_fail++; $display("FAIL basic_cmd0: got %h want 45", issued[0]); end
        n_checks++; if (issued[1] !== 8'h49) begin n_fail++; $display("FAIL basic_cmd1: got %h want 49", issued[1]); end
        n_checks++; if (rise_cyc[1] - arr_cyc[0] != int'(D) + 1) begin
            n_fail++; $display("FAIL basic_dwell_gap: got %0d want %0d", rise_cyc[1] - arr_cyc[0], int'(D) + 1);
        end
        n_checks++; if (route_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b want 1", route_empty); end
        n_checks++; if (cmd !== 8'h49) begin n_fail++; $display("FAIL basic_cmd_held: got %h want 49", cmd); end
        n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_cmd_rdy: got %b want 0", cmd_rdy); end
    endtask

    task automatic test_full_drain();
        int n;
        logic [7:0] exp;
        hold_transit = 1'b1;
        repeat (2) tick();
        for (int i = 1; i <= 5; i++) push(6'(i));
        tick();
        n_checks++; if (route_full !== 1'b1)  begin n_fail++; $display("FAIL full_flag: got %b want 1", route_full); end
        n_checks++; if (route_empty !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b want 0", route_empty); end
        n_checks++; if (cmd_rdy !== 1'b0)     begin n_fail++; $display("FAIL full_no_issue_in_transit: got %b want 0", cmd_rdy); end
        issued.delete();
        hold_transit = 1'b0;
        for (n = 0; n < 800 && !(issued.size() == 4 && !route_busy); n++) tick();
        repeat (40) tick();
        n_checks++; if (issued.size() != 4) begin n_fail++; $display("FAIL full_issue_count: got %0d want 4", issued.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = {2'b01, 6'(i + 1)};
            n_checks++; if (issued[i] !== exp) begin n_fail++; $display("FAIL full_order%0d: got %h want %h", i, issued[i], exp); end
        end
        n_checks++; if (route_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b want 1", route_empty); end
    endtask

    task automatic test_host_travel();
        int n;
        travel_len = 60;
        issued.delete(); hclr_cnt = 0; bad_coinc = 0;
        push(6'd7);
        push(6'd8);
        for (n = 0; n < 50 && issued.size() != 1; n++) tick();
        repeat (5) tick();
        n_checks++; if (route_busy !== 1'b1)  begin n_fail++; $display("FAIL ht_busy: got %b want 1", route_busy); end
        n_checks++; if (route_empty !== 1'b0) begin n_fail++; $display("FAIL ht_queued: got %b want 0", route_empty); end
        host_cmd = 8'h00; host_cmd_rdy = 1'b1;
        for (n = 0; n < 50 && !host_clr_cmd_rdy; n++) tick();
        n_checks++; if (host_clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL ht_host_clr_timeout: got %b want 1", host_clr_cmd_rdy); end
        n_checks++; if (clr_cmd_rdy !== 1'b1)  begin n_fail++; $display("FAIL ht_coincident: clr %b want 1", clr_cmd_rdy); end
        n_checks++; if (cmd !== 8'h00)         begin n_fail++; $display("FAIL ht_cmd: got %h want 00", cmd); end
        n_checks++; if (route_empty !== 1'b1)  begin n_fail++; $display("FAIL ht_flushed: got %b want 1", route_empty); end
        host_cmd_rdy = 1'b0;
        repeat (30) tick();
        n_checks++; if (issued.size() != 2)  begin n_fail++; $display("FAIL ht_issue_count: got %0d want 2", issued.size()); end
        n_checks++; if (issued[1] !== 8'h00) begin n_fail++; $display("FAIL ht_last: got %h want 00", issued[1]); end
        n_checks++; if (route_busy !== 1'b0) begin n_fail++; $display("FAIL ht_idle: got %b want 0", route_busy); end
        n_checks++; if (hclr_cnt != 1)       begin n_fail++; $display("FAIL ht_hclr_pulses: got %0d want 1", hclr_cnt); end
        n_checks++; if (bad_coinc != 0)      begin n_fail++; $display("FAIL ht_hclr_alone: got %0d want 0", bad_coinc); end
        travel_len = 20;
    endtask

    task automatic test_host_idle();
        int n;
        issued.delete();
        hold_transit = 1'b1;
        repeat (2) tick();
        push(6'd10);
        push(6'd11);
        repeat (5) tick();
        n_checks++; if (cmd_rdy !== 1'b0)    begin n_fail++; $display("FAIL hi_hold_issue: got %b want 0", cmd_rdy); end
        n_checks++; if (route_busy !== 1'b0) begin n_fail++; $display("FAIL hi_hold_busy: got %b want 0", route_busy); end
        hold_transit = 1'b0;
        tick();
        // in_transit is now low and the queue is non-empty: host must still win.
        host_cmd = 8'h52; host_cmd_rdy = 1'b1;
        for (n = 0; n < 50 && !host_clr_cmd_rdy; n++) tick();
        n_checks++; if (host_clr_cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL hi_host_clr_timeout: got %b want 1", host_clr_cmd_rdy); end
        n_checks++; if (issued[0] !== 8'h52) begin n_fail++; $display("FAIL hi_first: got %h want 52", issued[0]); end
        host_cmd_rdy = 1'b0;
        tick();
        n_checks++; if (route_empty !== 1'b1) begin n_fail++; $display("FAIL hi_flushed: got %b want 1", route_empty); end
        repeat (40) tick();
        n_checks++; if (issued.size() != 1) begin n_fail++; $display("FAIL hi_issue_count: got %0d want 1", issued.size()); end
        n_checks++; if (cmd !== 8'h52)      begin n_fail++; $display("FAIL hi_cmd_held: got %h want 52", cmd); end
    endtask

`ifdef ROUTE_LOOP_EN
    task automatic test_loop();
        int n;
        issued.delete();
        push(6'd3);
        push(6'd7);
        for (n = 0; n < 600 && issued.size() < 4; n++) tick();
        n_checks++; if (issued[0] !== 8'h43) begin n_fail++; $display("FAIL loop0: got %h want 43", issued[0]); end
        n_checks++; if (issued[1] !== 8'h47) begin n_fail++; $display("FAIL loop1: got %h want 47", issued[1]); end
        n_checks++; if (issued[2] !== 8'h43) begin n_fail++; $display("FAIL loop2: got %h want 43", issued[2]); end
        n_checks++; if (issued[3] !== 8'h47) begin n_fail++; $display("FAIL loop3: got %h want 47", issued[3]); end
        n_checks++; if (route_empty !== 1'b0 || route_full !== 1'b0) begin
            n_fail++; $display("FAIL loop_count: empty %b full %b want 0 0", route_empty, route_full);
        end
        host_cmd = 8'h00; host_cmd_rdy = 1'b1;
        for (n = 0; n < 100 && !host_clr_cmd_rdy; n++) tick();
        host_cmd_rdy = 1'b0;
        tick();
        n_checks++; if (route_empty !== 1'b1) begin n_fail++; $display("FAIL loop_stop_flush: got %b want 1", route_empty); end
        repeat (30) tick();
    endtask
`endif

    task automatic test_reset_dwell();
        int n;
        arr_cyc.delete();
        push(6'd20);
        push(6'd21);
        for (n = 0; n < 100 && !arrived; n++) tick();
        n_checks++; if (arrived !== 1'b1)    begin n_fail++; $display("FAIL rd_arrived_timeout: got %b want 1", arrived); end
        n_checks++; if (route_busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %b want 1", route_busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (cmd !== 8'h00)        begin n_fail++; $display("FAIL rd_cmd: got %h want 00", cmd); end
        n_checks++; if (cmd_rdy !== 1'b0)     begin n_fail++; $display("FAIL rd_cmd_rdy: got %b want 0", cmd_rdy); end
        n_checks++; if (arrived !== 1'b0)     begin n_fail++; $display("FAIL rd_arrived: got %b want 0", arrived); end
        n_checks++; if (route_busy !== 1'b0)  begin n_fail++; $display("FAIL rd_busy_clr: got %b want 0", route_busy); end
        n_checks++; if (route_empty !== 1'b1) begin n_fail++; $display("FAIL rd_empty: got %b want 1", route_empty); end
        n_checks++; if (route_full !== 1'b0)  begin n_fail++; $display("FAIL rd_full: got %b want 0", route_full); end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_route_basic();
        test_full_drain();
        test_host_travel();
        test_host_idle();
`ifdef ROUTE_LOOP_EN
        test_loop();
`endif
        test_reset_dwell();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
